// File: rtl/router_pkg.sv
// Constants and state encoding shared by the router controller, encapsulator
// and decapsulator: header widths, flit field offsets and the FSM encoding.
package router_pkg;

  localparam int NUMBER_PACKET_DEF          = 19;
  localparam int RECOGNIZE_ROUTER_WIDTH_DEF = 2;
  localparam int NUM_W = $clog2(NUMBER_PACKET_DEF);
  localparam int HDR_W = 2 + NUM_W + RECOGNIZE_ROUTER_WIDTH_DEF;

  // Flit layout: {payload, dst_addr, ttl, seq, src_router}
  localparam int HDR_LSB     = 0;
  localparam int SRC_LSB     = 0;
  localparam int SEQ_LSB     = RECOGNIZE_ROUTER_WIDTH_DEF;
  localparam int TTL_LSB     = SEQ_LSB + NUM_W;
  localparam int TTL_MSB     = TTL_LSB + 1;
  localparam int DST_LSB     = HDR_W;
  localparam int PAYLOAD_LSB = DST_LSB + 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } encap_state_e;

endpackage

// File: rtl/pkt_encapsulator.sv
// Router input-port-0 encapsulation stage: reads NUMBER_PACKET payload words
// from the source buffer and writes them as addressed Aurora flits to the FIFO.
module pkt_encapsulator
  import router_pkg::*;
#(
  parameter int AURORA_DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH             = 10,
  parameter int NUMBER_PACKET          = NUMBER_PACKET_DEF,
  parameter int RECOGNIZE_ROUTER_WIDTH = RECOGNIZE_ROUTER_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_encap_pkt,
  input  logic [ADDR_WIDTH-1:0]         router_dst_addr_send,
  input  logic [HDR_W-1:0]              header_pkt_send,
  input  logic [ADDR_WIDTH-1:0]         src_base_addr,
  output logic                          src_rd_en,
  output logic [ADDR_WIDTH-1:0]         src_rd_addr,
  input  logic [AURORA_DATA_WIDTH-ADDR_WIDTH-HDR_W-1:0] src_rd_data,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [AURORA_DATA_WIDTH-1:0]  fifo_wr_data,
  output logic                          encap_busy,
  output logic                          encap_done
);

  localparam int PAYLOAD_W = AURORA_DATA_WIDTH - ADDR_WIDTH - HDR_W;
  localparam logic [NUM_W-1:0] LAST_N = NUM_W'(NUMBER_PACKET - 1);

  encap_state_e                   state_q;
  logic [ADDR_WIDTH-1:0]          dst_q;
  logic [ADDR_WIDTH-1:0]          base_q;
  logic [NUM_W-1:0]               n_q;
  logic [1:0]                     ttl_q;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0] src_router_q;
  logic [PAYLOAD_W-1:0]           payload_q;
  logic                           src_rd_en_q;
  logic [ADDR_WIDTH-1:0]          src_rd_addr_q;
  logic                           encap_done_q;

  logic [NUM_W-1:0]               n_d;
  logic [ADDR_WIDTH-1:0]          rd_addr_d;
  logic                           unused_hdr;

  // The header's middle bits carry nothing this stage needs.
  assign unused_hdr = ^header_pkt_send[TTL_LSB-1:SEQ_LSB];

  always_comb begin
    n_d       = n_q + 1'b1;
    rd_addr_d = base_q + ADDR_WIDTH'(n_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      dst_q         <= '0;
      base_q        <= '0;
      n_q           <= '0;
      ttl_q         <= '0;
      src_router_q  <= '0;
      payload_q     <= '0;
      src_rd_en_q   <= 1'b0;
      src_rd_addr_q <= '0;
      encap_done_q  <= 1'b0;
    end else begin
      src_rd_en_q  <= 1'b0;
      encap_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_encap_pkt) begin
            dst_q   <= router_dst_addr_send;
            base_q  <= src_base_addr;
            n_q     <= '0;
            state_q <= ST_LATCH;
          end
        end
        // The controller presents the header one cycle after its start pulse.
        ST_LATCH: begin
          ttl_q         <= header_pkt_send[TTL_MSB:TTL_LSB];
          src_router_q  <= header_pkt_send[RECOGNIZE_ROUTER_WIDTH-1:0];
          src_rd_en_q   <= 1'b1;
          src_rd_addr_q <= base_q + ADDR_WIDTH'(n_q);
          state_q       <= ST_READ;
        end
        ST_READ: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          payload_q <= src_rd_data;
          state_q   <= ST_WRITE;
        end
        ST_WRITE: begin
          if (!fifo_full) begin
            if (n_q == LAST_N) begin
              encap_done_q <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              n_q           <= n_d;
              src_rd_en_q   <= 1'b1;
              src_rd_addr_q <= rd_addr_d;
              state_q       <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Write strobe follows fifo_full combinationally so a full that rises on
  // WRITE entry blocks that very cycle; the flit itself is all registers.
  assign fifo_wr_en   = (state_q == ST_WRITE) && !fifo_full;
  assign fifo_wr_data = {payload_q, dst_q, ttl_q, n_q, src_router_q};
  assign src_rd_en    = src_rd_en_q;
  assign src_rd_addr  = src_rd_addr_q;
  assign encap_busy   = (state_q != ST_IDLE);
  assign encap_done   = encap_done_q;

`ifndef SYNTHESIS
  a_no_write_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wr_en && fifo_full));
  a_flit_held_on_stall : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_WRITE && fifo_full) |=> $stable(fifo_wr_data));
`endif

endmodule

// File: tb/tb_pkt_encapsulator.sv
// Directed bench for pkt_encapsulator: a table of transfers driven cycle by
// cycle, plus a hand-written mid-transfer reset sequence.
module tb_pkt_encapsulator;

  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int NP    = 19;
  localparam int NUM_W = 5;
  localparam int HDR_W = 9;
  localparam int PW    = DW - AW - HDR_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_encap_pkt;
  logic [AW-1:0]    router_dst_addr_send;
  logic [HDR_W-1:0] header_pkt_send;
  logic [AW-1:0]    src_base_addr;
  logic             src_rd_en;
  logic [AW-1:0]    src_rd_addr;
  logic [PW-1:0]    src_rd_data;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic             encap_busy;
  logic             encap_done;

  pkt_encapsulator dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start_encap_pkt      (start_encap_pkt),
    .router_dst_addr_send (router_dst_addr_send),
    .header_pkt_send      (header_pkt_send),
    .src_base_addr        (src_base_addr),
    .src_rd_en            (src_rd_en),
    .src_rd_addr          (src_rd_addr),
    .src_rd_data          (src_rd_data),
    .fifo_full            (fifo_full),
    .fifo_wr_en           (fifo_wr_en),
    .fifo_wr_data         (fifo_wr_data),
    .encap_busy           (encap_busy),
    .encap_done           (encap_done)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source buffer model: data equals the address, valid one cycle after the
  // read strobe; otherwise a junk pattern so late/early capture shows up.
  always @(posedge clk)
    src_rd_data <= src_rd_en ? {{(PW-AW){1'b0}}, src_rd_addr} : 45'h1_ABCD_EF01_234;

  // ---------------- scoreboard ----------------
  int vectors_applied = 0;
  int miscompares     = 0;
  int t0 = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_q[$];
  int            wr_t[$];
  logic [AW-1:0] rd_q[$];
  int            done_t[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors_applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_wr_en) begin
        check("wr_while_full", 64'(fifo_full), 64'd0);
        wr_q.push_back(fifo_wr_data);
        wr_t.push_back(cyc - t0);
      end
      if (src_rd_en) rd_q.push_back(src_rd_addr);
      if (encap_done) done_t.push_back(cyc - t0);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] dst;
    logic [AW-1:0] base;
    logic [1:0]    ttl;
    logic [1:0]    src;
    int            gap;
    int            stall_flit;
    int            stall_len;
    int            second_start;
    logic [AW-1:0] second_dst;
    int            abort_at;
    int            exp_done;
  } vec_t;

  function automatic vec_t mk(input logic [AW-1:0] dst, input logic [AW-1:0] base,
                              input logic [1:0] ttl, input logic [1:0] src, input int gap,
                              input int stall_flit, input int stall_len,
                              input int second_start, input logic [AW-1:0] second_dst,
                              input int abort_at, input int exp_done);
    vec_t v;
    v.dst = dst; v.base = base; v.ttl = ttl; v.src = src; v.gap = gap;
    v.stall_flit = stall_flit; v.stall_len = stall_len;
    v.second_start = second_start; v.second_dst = second_dst;
    v.abort_at = abort_at; v.exp_done = exp_done;
    return v;
  endfunction

  vec_t vecs[5];

  // ---------------- driver ----------------
  // Entered and left just after a rising edge; leaves on the first IDLE cycle.
  task automatic run_transfer(input vec_t v);
    repeat (v.gap) begin @(posedge clk); #1; end
    wr_q.delete(); wr_t.delete(); rd_q.delete(); done_t.delete();
    t0 = cyc;
    for (int rel = 0; rel < 200; rel++) begin
      start_encap_pkt      = (rel == 0) || (rel == v.second_start);
      router_dst_addr_send = (rel == 0) ? v.dst : v.second_dst;
      src_base_addr        = (rel == 0) ? v.base : ~v.base;
      header_pkt_send      = (rel == 1) ? {v.ttl, 5'b00000, v.src}
                                        : {~v.ttl, 5'b10101, ~v.src};
      fifo_full = (v.stall_len > 0) && (rel >= 4 + 3 * v.stall_flit) &&
                  (rel < 4 + 3 * v.stall_flit + v.stall_len);
      if (v.abort_at >= 0 && rel == v.abort_at) begin
        rst_n = 1'b0;
        break;
      end
      if (done_t.size() > 0 && rel > done_t[0]) begin
        check("busy_after_done", 64'(encap_busy), 64'd0);
        break;
      end
      @(posedge clk); #1;
    end
    start_encap_pkt = 1'b0;
    fifo_full       = 1'b0;
  endtask

  task automatic check_transfer(input vec_t v, input int idx);
    logic [AW-1:0] a;
    int            exp_t;
    exp_q.delete();
    for (int k = 0; k < NP; k++) begin
      a = v.base + AW'(k);
      exp_q.push_back({{(PW-AW){1'b0}}, a, v.dst, v.ttl, NUM_W'(k), v.src});
    end
    check($sformatf("t%0d_done_count", idx), 64'(done_t.size()), 64'd1);
    if (done_t.size() > 0)
      check($sformatf("t%0d_done_cycle", idx), 64'(done_t[0]), 64'(v.exp_done));
    check($sformatf("t%0d_write_count", idx), 64'(wr_q.size()), 64'(NP));
    check($sformatf("t%0d_read_count", idx), 64'(rd_q.size()), 64'(NP));
    for (int k = 0; k < NP && k < wr_q.size(); k++) begin
      check($sformatf("t%0d_flit%0d", idx, k), wr_q[k], exp_q[k]);
      exp_t = 4 + 3 * k + ((v.stall_len > 0 && k >= v.stall_flit) ? v.stall_len : 0);
      check($sformatf("t%0d_flit%0d_cycle", idx, k), 64'(wr_t[k]), 64'(exp_t));
    end
    for (int k = 0; k < NP && k < rd_q.size(); k++)
      check($sformatf("t%0d_rd_addr%0d", idx, k), 64'(rd_q[k]), 64'(AW'(v.base + AW'(k))));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t rv;
    vec_t fv;
    // dst, base, ttl, src, gap, stall_flit, stall_len, 2nd start, 2nd dst, abort, done
    vecs[0] = mk(10'h155, 10'h040, 2'd3, 2'd2, 2, 0, 0, -1, 10'h000, -1, 59); // nominal
    vecs[1] = mk(10'h0AA, 10'h100, 2'd1, 2'd1, 0, 7, 5, -1, 10'h000, -1, 64); // back-to-back + stall
    vecs[2] = mk(10'h3C3, 10'h3F8, 2'd2, 2'd0, 3, 0, 0, -1, 10'h000, -1, 59); // address wrap
    vecs[3] = mk(10'h123, 10'h200, 2'd0, 2'd3, 1, 0, 0, 20, 10'h2FF, -1, 59); // start while busy
    vecs[4] = mk(10'h2D2, 10'h00F, 2'd3, 2'd1, 0, 0, 0, 59, 10'h111, -1, 59); // start in DONE
    rv      = mk(10'h111, 10'h000, 2'd1, 2'd3, 2, 0, 0, -1, 10'h000, 30, 59);
    fv      = mk(10'h0F0, 10'h3FF, 2'd2, 2'd2, 2, 0, 0, -1, 10'h000, -1, 59);

    rst_n = 1'b0;
    start_encap_pkt = 1'b0;
    router_dst_addr_send = '0;
    header_pkt_send = '0;
    src_base_addr = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_src_rd_en",   64'(src_rd_en),    64'd0);
    check("rst_src_rd_addr", 64'(src_rd_addr),  64'd0);
    check("rst_fifo_wr_en",  64'(fifo_wr_en),   64'd0);
    check("rst_fifo_wr_data", fifo_wr_data,     64'd0);
    check("rst_busy",        64'(encap_busy),   64'd0);
    check("rst_done",        64'(encap_done),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_transfer(vecs[i]);
      check_transfer(vecs[i], i);
    end

    // Reset at cycle 30: flits 0..8 are out (last at cycle 28), nothing more.
    run_transfer(rv);
    #1;
    check("abort_src_rd_en",   64'(src_rd_en),   64'd0);
    check("abort_src_rd_addr", 64'(src_rd_addr), 64'd0);
    check("abort_fifo_wr_en",  64'(fifo_wr_en),  64'd0);
    check("abort_fifo_wr_data", fifo_wr_data,    64'd0);
    check("abort_busy",        64'(encap_busy),  64'd0);
    check("abort_done",        64'(encap_done),  64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_write_count", 64'(wr_q.size()),   64'd9);
    check("abort_done_count",  64'(done_t.size()), 64'd0);
    check("abort_idle_busy",   64'(encap_busy),    64'd0);

    run_transfer(fv);
    check_transfer(fv, 5);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
